regfile_wport_arbiter: RTL and testbench
========================================

// Module: regfile_wport_arbiter
// PURPOSE
//  Shares the single register-file write port between two writers.
//  - Port 0: in-order pipeline writeback.
//  - Port 1: long-latency unit (mult/div, load return), buffered in a small FIFO.
//  Keeps a scoreboard of destinations issued to the long-latency unit, so decode can stall on RAW hazards.
//  Sits between the WB stage / long-latency unit and the regfile write port (waddr/wdata/we).
// PARAMETERS
//  ADDR_W        5   register address width (= `RegAddrWidth)
//  DATA_W        32  register data width (= `RegDataWidth)
//  FIFO_DEPTH    4   port-1 buffer entries, power of two, >=2
//  STARVE_LIMIT  3   consecutive port-1 losses before port 1 is forced to win
// PORTS
//  clk        in   1       clock
//  rst        in   1       asynchronous reset, active-low
//  p0_valid   in   1       port-0 write request
//  p0_addr    in   ADDR_W  port-0 destination
//  p0_data    in   DATA_W  port-0 data
//  p0_ready   out  1       port-0 accepted this cycle; 0 = pipeline must stall WB
//  p1_valid   in   1       port-1 write request
//  p1_addr    in   ADDR_W  port-1 destination
//  p1_data    in   DATA_W  port-1 data
//  p1_ready   out  1       FIFO not full
//  iss_valid  in   1       long-latency op issued
//  iss_addr   in   ADDR_W  its destination; marks scoreboard busy
//  rd_addr1   in   ADDR_W  decode read address 1
//  rd_addr2   in   ADDR_W  decode read address 2
//  rd_busy1   out  1       rd_addr1 has a pending port-1 write
//  rd_busy2   out  1       rd_addr2 has a pending port-1 write
//  rf_we      out  1       regfile write enable (registered)
//  rf_waddr   out  ADDR_W  regfile write address (registered)
//  rf_wdata   out  DATA_W  regfile write data (registered)
//  fifo_cnt   out  clog2(FIFO_DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - all outputs are 0 immediately, except p1_ready=1;
//   - FIFO, scoreboard and starve counter are cleared;
//   - in-flight requests are dropped.
//  Handshakes:
//   - port-1 push when p1_valid & p1_ready;
//   - port-0 transfer when p0_valid & p0_ready.
//  Grant, evaluated each cycle:
//   - force = fifo non-empty & starve_cnt==STARVE_LIMIT.
//   - Grant port 0 if p0_valid & !force.
//   - Else grant the FIFO head if non-empty.
//   - Else idle.
//   - p0_ready = !force.
//  Starve counter:
//   - increments (saturating) when FIFO is non-empty and port 0 wins;
//   - clears on every FIFO pop.
//  Output register:
//   - on any grant: rf_we<=(addr!=0), rf_waddr/rf_wdata<=granted request;
//   - otherwise rf_we<=0;
//   - latency request->rf_we is 1 cycle;
//   - address-0 writes are consumed but never asserted on rf_we.
//  FIFO:
//   - p1_ready is derived from registered occupancy;
//   - no push when full, even with a simultaneous pop;
//   - push and pop in the same cycle keep the count;
//   - pointers wrap modulo FIFO_DEPTH.
//  Scoreboard (busy[2**ADDR_W], bit 0 hardwired 0):
//   - iss_valid sets busy[iss_addr];
//   - a FIFO pop clears busy[head addr];
//   - same-cycle set and clear of one address: set wins;
//   - rd_busyN = busy[rd_addrN], combinational.
// CONFIGURATION
//  `REGARB_FWD_EN defined: add outputs fwd_hit1/2 (1) and fwd_data1/2 (DATA_W).
//   - fwd_hitN = rf_we & rf_waddr==rd_addrN; fwd_dataN = rf_wdata.
//   - rd_busyN is masked to 0 when fwd_hitN.
//  Undefined: these ports do not exist; rd_busyN is unmasked.
// STRUCTURE
//  - Add constants RegArbFifoDepth and RegArbStarveLimit to define.v next to the RegAddrWidth/RegDataWidth defines.
//  - One sub-module: regarb_fifo.
//   - Synchronous FIFO of {addr,data}; push/pop/full/empty/count.
//   - Async active-low reset.
//  - Grant logic, starve counter, scoreboard and output register live in the top module.
// TESTING
//  1. Reset mid-stream: assert rst=0 with 3 entries queued.
//     -> rf_we=0 and fifo_cnt=0 same cycle; rd_busy=0 after release.
//  2. p0 only: addr 5, data 0xDEADBEEF.
//     -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
//  3. Starvation: p0_valid held high, one p1 push to addr 7.
//     -> p0 wins 3 cycles, then p0_ready=0 for 1 cycle.
//     -> then rf_waddr=7 and busy[7] clears.
//  4. FIFO full: 4 pushes while p0 is continuously valid.
//     -> p1_ready=0 at fifo_cnt=4; 5th push is refused, not lost.
//  5. Scoreboard: iss addr 9, rd_addr1=9 -> rd_busy1=1 until the p1 write to 9 reaches rf_we.
//     Issue to 9 in the same cycle as that pop -> busy stays 1.
//  6. Address 0: p0 and p1 writes to 0 are consumed; rf_we stays 0; rd_busy for address 0 is always 0.

Source files
------------

// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Optional feature macro used by this slice: REGARB_FWD_EN.
package regfile_wport_arbiter_pkg;

    localparam int RegAddrWidth      = 5;
    localparam int RegDataWidth      = 32;
    localparam int RegArbFifoDepth   = 4;
    localparam int RegArbStarveLimit = 3;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_P0   = 2'd1,
        GNT_P1   = 2'd2
    } grant_e;

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// Bundle of the writer, issue, decode-read and regfile-write signals of the arbiter.
// REGARB_FWD_EN adds the decode forwarding outputs.
interface regfile_wport_arbiter_if
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int ADDR_W = RegAddrWidth,
    parameter int DATA_W = RegDataWidth,
    parameter int CNT_W  = $clog2(RegArbFifoDepth) + 1
);
    logic              p0_valid;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_data;
    logic              p0_ready;
    logic              p1_valid;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_data;
    logic              p1_ready;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_addr;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [CNT_W-1:0]  fifo_cnt;
`ifdef REGARB_FWD_EN
    logic              fwd_hit1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data1;
    logic [DATA_W-1:0] fwd_data2;
`endif

    modport master (
        output p0_valid, p0_addr, p0_data, p1_valid, p1_addr, p1_data,
               iss_valid, iss_addr, rd_addr1, rd_addr2,
`ifdef REGARB_FWD_EN
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
        input  p0_ready, p1_ready, rd_busy1, rd_busy2,
               rf_we, rf_waddr, rf_wdata, fifo_cnt
    );

    modport slave (
        input  p0_valid, p0_addr, p0_data, p1_valid, p1_addr, p1_data,
               iss_valid, iss_addr, rd_addr1, rd_addr2,
`ifdef REGARB_FWD_EN
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
        output p0_ready, p1_ready, rd_busy1, rd_busy2,
               rf_we, rf_waddr, rf_wdata, fifo_cnt
    );

endinterface

// File: rtl/regfile_wport_arbiter_fifo.sv
// regarb_fifo: synchronous FIFO buffering long-latency writebacks as {addr,data}.
// Pushes while full and pops while empty are ignored.
module regarb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; occupancy is governed by count/pointers,
    // so stale contents are never observed and the array can map to plain flops/RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Shares the regfile write port between the WB stage (port 0) and a FIFO-buffered
// long-latency unit (port 1), with a RAW scoreboard. REGARB_FWD_EN adds forwarding outputs.
module regfile_wport_arbiter
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int ADDR_W       = RegAddrWidth,
    parameter int DATA_W       = RegDataWidth,
    parameter int FIFO_DEPTH   = RegArbFifoDepth,
    parameter int STARVE_LIMIT = RegArbStarveLimit
) (
    input logic                    clk,
    input logic                    rst,
    regfile_wport_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam int NREG  = 2 ** ADDR_W;

    logic [ADDR_W+DATA_W-1:0] head;
    logic [ADDR_W-1:0]        head_addr;
    logic [DATA_W-1:0]        head_data;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic                     force_p1;
    logic [STV_W-1:0]         starve_cnt;
    logic [NREG-1:0]          busy;
    logic [NREG-1:0]          busy_next;
    grant_e                   grant;
    logic                     rf_we_q;
    logic [ADDR_W-1:0]        rf_waddr_q;
    logic [DATA_W-1:0]        rf_wdata_q;
    logic                     hit1;
    logic                     hit2;

    regarb_fifo #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({bus.p1_addr, bus.p1_data}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (bus.fifo_cnt)
    );

    assign {head_addr, head_data} = head;

    assign force_p1     = !fifo_empty && (starve_cnt == STV_W'(STARVE_LIMIT));
    assign push         = bus.p1_valid && !fifo_full;
    assign pop          = (grant == GNT_P1);
    // Held low during reset so every output except p1_ready reads 0.
    assign bus.p0_ready = rst && !force_p1;
    assign bus.p1_ready = !fifo_full;

    // NOTE: every signal written in a combinational block gets a default first,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        grant = GNT_NONE;
        if (bus.p0_valid && !force_p1) grant = GNT_P0;
        else if (!fifo_empty)          grant = GNT_P1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (pop) begin
            starve_cnt <= '0;
        end else if (grant == GNT_P0 && !fifo_empty && starve_cnt != STV_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // A same-cycle issue to the popped address must win, so the set is applied last.
    always_comb begin
        busy_next = busy;
        if (pop)           busy_next[head_addr]    = 1'b0;
        if (bus.iss_valid) busy_next[bus.iss_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy <= '0;
        else      busy <= busy_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            case (grant)
                GNT_P0: begin
                    rf_we_q    <= (bus.p0_addr != '0);
                    rf_waddr_q <= bus.p0_addr;
                    rf_wdata_q <= bus.p0_data;
                end
                GNT_P1: begin
                    rf_we_q    <= (head_addr != '0);
                    rf_waddr_q <= head_addr;
                    rf_wdata_q <= head_data;
                end
                default: rf_we_q <= 1'b0;
            endcase
        end
    end

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;

`ifdef REGARB_FWD_EN
    assign hit1          = rf_we_q && (rf_waddr_q == bus.rd_addr1);
    assign hit2          = rf_we_q && (rf_waddr_q == bus.rd_addr2);
    assign bus.fwd_hit1  = hit1;
    assign bus.fwd_hit2  = hit2;
    assign bus.fwd_data1 = rf_wdata_q;
    assign bus.fwd_data2 = rf_wdata_q;
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    assign bus.rd_busy1 = busy[bus.rd_addr1] && !hit1;
    assign bus.rd_busy2 = busy[bus.rd_addr2] && !hit2;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Scoreboard bench for regfile_wport_arbiter: directed scenarios plus random traffic
// against a queue-based reference model. Honours REGARB_FWD_EN when defined.
`timescale 1ns/1ps
module tb_regfile_wport_arbiter;
    import regfile_wport_arbiter_pkg::*;

    localparam int AW    = RegAddrWidth;
    localparam int DW    = RegDataWidth;
    localparam int DEPTH = RegArbFifoDepth;
    localparam int LIMIT = RegArbStarveLimit;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int unsigned   due;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;

    ent_t          mq[$];
    wr_t           sb[$];
    int            starve;
    bit            mbusy[2**AW];
    bit            last_we;
    logic [AW-1:0] last_a;
    logic [DW-1:0] last_d;
    bit            push_ok;

    regfile_wport_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

    regfile_wport_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_busy(input logic [AW-1:0] r);
        bit b;
        b = (r != '0) && mbusy[r];
`ifdef REGARB_FWD_EN
        if (last_we && last_a == r) b = 1'b0;
`endif
        return b;
    endfunction

    task automatic model_clear();
        mq.delete();
        sb.delete();
        starve  = 0;
        last_we = 1'b0;
        foreach (mbusy[i]) mbusy[i] = 1'b0;
    endtask

    task automatic drive_idle();
        bus.p0_valid  = 1'b0; bus.p0_addr = '0; bus.p0_data = '0;
        bus.p1_valid  = 1'b0; bus.p1_addr = '0; bus.p1_data = '0;
        bus.iss_valid = 1'b0; bus.iss_addr = '0;
        bus.rd_addr1  = '0;   bus.rd_addr2 = '0;
    endtask

    // One clock of stimulus: drive, compare combinational outputs, advance the model.
    task automatic step(input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input bit iv, input logic [AW-1:0] ia,
                        input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        bit   frc;
        bit   full;
        bit   nonempty;
        ent_t h;
        @(negedge clk);
        bus.p0_valid = v0; bus.p0_addr = a0; bus.p0_data = d0;
        bus.p1_valid = v1; bus.p1_addr = a1; bus.p1_data = d1;
        bus.iss_valid = iv; bus.iss_addr = ia;
        bus.rd_addr1 = r1; bus.rd_addr2 = r2;
        #1;
        nonempty = (mq.size() != 0);
        full     = (mq.size() == DEPTH);
        frc      = nonempty && (starve == LIMIT);
        check("p0_ready", bus.p0_ready, !frc);
        check("p1_ready", bus.p1_ready, !full);
        check("fifo_cnt", bus.fifo_cnt, mq.size());
        check("rd_busy1", bus.rd_busy1, exp_busy(r1));
        check("rd_busy2", bus.rd_busy2, exp_busy(r2));
`ifdef REGARB_FWD_EN
        check("fwd_hit1", bus.fwd_hit1, last_we && last_a == r1);
        if (last_we) check("fwd_data1", bus.fwd_data1, last_d);
`endif
        last_we = 1'b0;
        if (v0 && !frc) begin
            if (a0 != '0) sb.push_back('{a0, d0, cyc + 1});
            last_we = (a0 != '0); last_a = a0; last_d = d0;
            if (nonempty && starve < LIMIT) starve++;
        end else if (nonempty) begin
            h = mq.pop_front();
            if (h.a != '0) sb.push_back('{h.a, h.d, cyc + 1});
            last_we = (h.a != '0); last_a = h.a; last_d = h.d;
            starve = 0;
            mbusy[h.a] = 1'b0;
        end
        push_ok = v1 && !full;
        if (push_ok) mq.push_back('{a1, d1});
        if (iv && ia != '0) mbusy[ia] = 1'b1;
    endtask

    task automatic do_reset(input logic [AW-1:0] probe);
        @(negedge clk);
        #2;
        check("pre_rst_cnt", bus.fifo_cnt, mq.size());
        rst = 1'b0;
        #1;
        check("rst_rf_we", bus.rf_we, 1'b0);
        check("rst_fifo_cnt", bus.fifo_cnt, 0);
        check("rst_p1_ready", bus.p1_ready, 1'b1);
        check("rst_p0_ready", bus.p0_ready, 1'b0);
        model_clear();
        drive_idle();
        @(negedge clk);
        #2;
        rst = 1'b1;
        bus.rd_addr1 = probe;
        #1;
        check("post_rst_busy", bus.rd_busy1, 1'b0);
    endtask

    // Monitor: every cycle, rf_we must match whether a scoreboard write is due now.
    initial begin
        wr_t w;
        bit  due;
        forever begin
            @(negedge clk);
            if (rst) begin
                due = (sb.size() != 0) && (sb[0].due == cyc);
                check("rf_we", bus.rf_we, due);
                if (due) begin
                    w = sb.pop_front();
                    if (bus.rf_we) begin
                        check("rf_waddr", bus.rf_waddr, w.a);
                        check("rf_wdata", bus.rf_wdata, w.d);
                    end
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] pd;
        drive_idle();
        model_clear();
        #12 rst = 1'b1;

        // Writeback-only transfer.
        step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Starvation: one long-latency write while WB stays busy.
        step(0, 0, 0, 0, 0, 0, 1, 5'd7, 7, 0);
        for (int i = 0; i < 7; i++)
            step(1, 5'd3, 32'h100 + i, i == 0, 5'd7, 32'h7777_0007, 0, 0, 7, 3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);

        // FIFO fills under continuous WB traffic; refused pushes are re-presented.
        pd = 32'hA000_0000;
        for (int i = 0; i < 10; i++) begin
            step(1, 5'd4, 32'h200 + i, pd < 32'hA000_0005, 5'd10 + 5'(pd[2:0]), pd, 0, 0, 10, 11);
            if (push_ok) pd++;
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Scoreboard: issue to 9, then re-issue in the cycle its FIFO entry pops.
        step(0, 0, 0, 0, 0, 0, 1, 5'd9, 9, 0);
        step(0, 0, 0, 1, 5'd9, 32'h9999_0001, 0, 0, 9, 0);
        step(0, 0, 0, 0, 0, 0, 1, 5'd9, 9, 0);
        step(0, 0, 0, 1, 5'd9, 32'h9999_0002, 0, 0, 9, 9);
        step(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
        step(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);

        // Address 0 is consumed silently and never busy.
        step(1, 5'd0, 32'h0BAD_0000, 1, 5'd0, 32'h0BAD_0001, 1, 5'd0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset with three entries queued.
        step(1, 5'd2, 32'h22, 1, 5'd12, 32'h1212, 1, 5'd12, 12, 0);
        step(1, 5'd2, 32'h23, 1, 5'd13, 32'h1313, 0, 0, 12, 0);
        step(1, 5'd2, 32'h24, 1, 5'd14, 32'h1414, 0, 0, 12, 0);
        do_reset(5'd12);

        // Randomised traffic with one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset(5'($urandom_range(1, 31)));
            step($urandom_range(0, 9) < 6, 5'($urandom), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 15)), $urandom,
                 $urandom_range(0, 9) < 3, 5'($urandom_range(0, 15)),
                 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
        end

        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #2;
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
